mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/rr_arbiter2.sv | 28 ++
 rtl/mem_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// ============================================================================
// mem_arb_pkg : shared types and constants for the two-port memory arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package mem_arb_pkg;

    localparam int DEF_DATA_WIDTH     = 8;
    localparam int DEF_DATA_DIR_WIDTH = 8;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter2.sv
// ============================================================================
// rr_arbiter2 : two-way round-robin pick with one-hot grant
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // On a tie, whoever was not served last goes first
            2'b11:   gnt = (last == REQ_A) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
// mem_arbiter : round-robin arbiter sharing one memory port between a
//               pipeline requester (a) and a loader requester (b)
// Rev 1.0
// ============================================================================
`default_nettype none

module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int DATA_DIR_WIDTH = DEF_DATA_DIR_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      a_req,
    input  logic                      a_we,
    input  logic [DATA_DIR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0]     a_wdata,
    output logic                      a_gnt,
    output logic                      a_rvalid,
    output logic [DATA_WIDTH-1:0]     a_rdata,

    input  logic                      b_req,
    input  logic                      b_we,
    input  logic [DATA_DIR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0]     b_wdata,
    output logic                      b_gnt,
    output logic                      b_rvalid,
    output logic [DATA_WIDTH-1:0]     b_rdata,

    output logic                      mem_we,
    output logic                      mem_re,
    output logic [DATA_DIR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    state_e                    state_q, state_d;
    logic                      last_q, last_d;
    logic                      owner_q, owner_d;
    logic                      we_q, we_d;
    logic [DATA_DIR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]     a_rdata_q, a_rdata_d;
    logic [DATA_WIDTH-1:0]     b_rdata_q, b_rdata_d;

    logic [1:0]                w_pick;
    logic                      w_idle;
    logic                      w_any_gnt;

    rr_arbiter2 u_rr (
        .req  ({b_req, a_req}),
        .last (last_q),
        .gnt  (w_pick)
    );

    // Grants are suppressed while reset is held low
    assign w_idle    = (state_q == IDLE) && rst;
    assign a_gnt     = w_idle && w_pick[0];
    assign b_gnt     = w_idle && w_pick[1];
    assign w_any_gnt = a_gnt || b_gnt;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        owner_d   = owner_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        case (state_q)
            IDLE: begin
                if (w_any_gnt) begin
                    state_d = ACCESS;
                    last_d  = b_gnt ? REQ_B : REQ_A;
                    owner_d = b_gnt ? REQ_B : REQ_A;
                    we_d    = b_gnt ? b_we    : a_we;
                    addr_d  = b_gnt ? b_addr  : a_addr;
                    wdata_d = b_gnt ? b_wdata : a_wdata;
                end
            end
            ACCESS: begin
                state_d = RESP;
                if (!we_q) begin
                    if (owner_q == REQ_B) b_rdata_d = mem_rdata;
                    else                  a_rdata_d = mem_rdata;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            last_q    <= REQ_B;
            owner_q   <= REQ_A;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            owner_q   <= owner_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // The captured address/data registers double as the held memory-side bus
    assign mem_we    = (state_q == ACCESS) &&  we_q;
    assign mem_re    = (state_q == ACCESS) && !we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    assign a_rvalid  = (state_q == RESP) && (owner_q == REQ_A);
    assign b_rvalid  = (state_q == RESP) && (owner_q == REQ_B);
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ============================================================================
// tb_mem_arbiter : directed scenarios plus randomized traffic for mem_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_mem_arbiter;

    logic       clk, rst;
    logic       a_req, a_we, a_gnt, a_rvalid;
    logic [7:0] a_addr, a_wdata, a_rdata;
    logic       b_req, b_we, b_gnt, b_rvalid;
    logic [7:0] b_addr, b_wdata, b_rdata;
    logic       mem_we, mem_re;
    logic [7:0] mem_addr, mem_wdata, mem_rdata;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int we_cycles = 0;
    int overlap = 0;

    logic [7:0] mem [4];

    // Reference model state (transaction level)
    int         m_phase;
    bit         m_last, m_own, m_we, ga, gb;
    logic [7:0] m_addr, m_wdata;
    logic [7:0] m_mem [4];
    logic [7:0] m_rd [2];

    mem_arbiter #(.DATA_WIDTH(8), .DATA_DIR_WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Team 4-entry data memory, reset image {3,2,0,0}
    assign mem_rdata = mem[mem_addr[1:0]];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_we) we_cycles <= we_cycles + 1;
        if (mem_we && mem_re) overlap <= overlap + 1;
        if (!rst) begin
            mem[0] <= 8'h03; mem[1] <= 8'h02; mem[2] <= 8'h00; mem[3] <= 8'h00;
        end else if (mem_we) begin
            mem[mem_addr[1:0]] <= mem_wdata;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    endtask

    // One isolated access from port p (0=a, 1=b), checked cycle by cycle
    task automatic serve(input bit p, input bit we, input logic [7:0] addr,
                         input logic [7:0] wdata, input logic [7:0] exp_rd, input string tag);
        @(negedge clk);
        if (!p) begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
        else    begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; end
        #1;
        chk({tag, ".gnt_a"}, a_gnt, p == 0);
        chk({tag, ".gnt_b"}, b_gnt, p == 1);
        @(negedge clk);
        a_req = 0; b_req = 0;
        #1;
        chk({tag, ".mem_we"}, mem_we, we);
        chk({tag, ".mem_re"}, mem_re, !we);
        chk({tag, ".mem_addr"}, mem_addr, addr);
        if (we) chk({tag, ".mem_wdata"}, mem_wdata, wdata);
        @(negedge clk);
        #1;
        chk({tag, ".rvalid_a"}, a_rvalid, p == 0);
        chk({tag, ".rvalid_b"}, b_rvalid, p == 1);
        chk({tag, ".rdata"}, p ? b_rdata : a_rdata, exp_rd);
    endtask

    task automatic rand_fields(input bit p);
        if (!p) begin
            a_we = 1'($urandom_range(1)); a_addr = 8'($urandom); a_wdata = 8'($urandom);
        end else begin
            b_we = 1'($urandom_range(1)); b_addr = 8'($urandom); b_wdata = 8'($urandom);
        end
    endtask

    initial begin
        int w0;
        int last_gnt_cyc;
        bit exp_a;

        // Reset, with a request held to show no grant leaks through
        rst = 0;
        drive_idle();
        a_req = 1;
        @(negedge clk); #1;
        chk("rst.a_gnt", a_gnt, 0);
        chk("rst.b_gnt", b_gnt, 0);
        chk("rst.mem_we", mem_we, 0);
        chk("rst.mem_re", mem_re, 0);
        chk("rst.a_rvalid", a_rvalid, 0);
        chk("rst.b_rvalid", b_rvalid, 0);
        chk("rst.a_rdata", a_rdata, 0);
        chk("rst.b_rdata", b_rdata, 0);
        chk("rst.mem_addr", mem_addr, 0);
        chk("rst.mem_wdata", mem_wdata, 0);
        @(negedge clk);
        rst = 1; a_req = 0;

        // Single read
        serve(0, 0, 8'h00, 8'h00, 8'h03, "s1");
        chk("s1.b_rdata", b_rdata, 0);

        // Write then read-back on b
        w0 = we_cycles;
        serve(1, 1, 8'h02, 8'h5A, 8'h00, "s2w");
        serve(1, 0, 8'h02, 8'h00, 8'h5A, "s2r");
        chk("s2.we_cycles", we_cycles - w0, 1);

        // Contention: b was served last, so a leads
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 8'h01;
        b_req = 1; b_we = 0; b_addr = 8'h00;
        last_gnt_cyc = 0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            exp_a = (k % 2 == 0);
            chk("s3.gnt_a", a_gnt, exp_a);
            chk("s3.gnt_b", b_gnt, !exp_a);
            if (k > 0) chk("s3.gap", cyc - last_gnt_cyc, 3);
            last_gnt_cyc = cyc;
            @(negedge clk); #1;
            chk("s3.mem_re", mem_re, 1);
            @(negedge clk);
            if (k == 3) begin a_req = 0; b_req = 0; end
            #1;
            chk("s3.rvalid", exp_a ? a_rvalid : b_rvalid, 1);
            chk("s3.rdata", exp_a ? a_rdata : b_rdata, exp_a ? 8'h02 : 8'h03);
        end

        // Late arrival: b raised during a's ACCESS
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 8'h03;
        #1;
        chk("s4.a_gnt", a_gnt, 1);
        @(negedge clk);
        a_req = 0; b_req = 1; b_we = 0; b_addr = 8'h01;
        #1;
        chk("s4.b_gnt_access", b_gnt, 0);
        chk("s4.mem_re", mem_re, 1);
        @(negedge clk); #1;
        chk("s4.a_rvalid", a_rvalid, 1);
        chk("s4.a_rdata", a_rdata, 8'h00);
        chk("s4.b_gnt_resp", b_gnt, 0);
        @(negedge clk); #1;
        chk("s4.b_gnt", b_gnt, 1);
        @(negedge clk);
        b_req = 0;
        #1;
        chk("s4.b_mem_re", mem_re, 1);
        chk("s4.b_mem_addr", mem_addr, 8'h01);
        @(negedge clk); #1;
        chk("s4.b_rvalid", b_rvalid, 1);
        chk("s4.b_rdata", b_rdata, 8'h02);
        chk("s4.overlap", overlap, 0);

        // Reset during ACCESS of an a-write; a is last-granted going in
        @(negedge clk);
        a_req = 1; a_we = 1; a_addr = 8'h01; a_wdata = 8'h77;
        #1;
        chk("s5.a_gnt", a_gnt, 1);
        @(negedge clk);
        a_req = 0; rst = 0;
        #1;
        chk("s5.mem_we", mem_we, 1);
        chk("s5.a_gnt_rst", a_gnt, 0);
        @(negedge clk);
        rst = 1;
        #1;
        chk("s5.a_rvalid", a_rvalid, 0);
        chk("s5.b_rvalid", b_rvalid, 0);
        chk("s5.mem_we0", mem_we, 0);
        chk("s5.mem_re0", mem_re, 0);
        chk("s5.mem_addr0", mem_addr, 0);
        chk("s5.mem_wdata0", mem_wdata, 0);
        chk("s5.a_rdata0", a_rdata, 0);
        chk("s5.b_rdata0", b_rdata, 0);
        @(negedge clk);
        a_req = 1; a_we = 0; a_addr = 8'hFD;
        b_req = 1; b_we = 0; b_addr = 8'h00;
        #1;
        chk("s5.tie_a", a_gnt, 1);
        chk("s5.tie_b", b_gnt, 0);
        @(negedge clk);
        a_req = 0; b_req = 0;
        #1;
        chk("s6.mem_re", mem_re, 1);
        chk("s6.mem_addr", mem_addr, 8'hFD);
        @(negedge clk); #1;
        chk("s6.a_rvalid", a_rvalid, 1);
        chk("s6.a_rdata", a_rdata, 8'h02);
        chk("s6.b_rvalid", b_rvalid, 0);

        // Randomized traffic against the transaction-level model
        @(negedge clk);
        rst = 0; drive_idle();
        @(negedge clk);
        rst = 1;
        m_phase = 0; m_last = 1; m_own = 0; m_we = 0;
        m_addr = 0; m_wdata = 0;
        m_mem[0] = 8'h03; m_mem[1] = 8'h02; m_mem[2] = 8'h00; m_mem[3] = 8'h00;
        m_rd[0] = 0; m_rd[1] = 0;
        ga = 0; gb = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ga) begin
                if ($urandom_range(1) == 0) a_req = 0; else rand_fields(0);
            end else if (a_req) begin
                if ($urandom_range(9) == 0) a_req = 0;
            end else if ($urandom_range(2) == 0) begin
                a_req = 1; rand_fields(0);
            end
            if (gb) begin
                if ($urandom_range(1) == 0) b_req = 0; else rand_fields(1);
            end else if (b_req) begin
                if ($urandom_range(9) == 0) b_req = 0;
            end else if ($urandom_range(2) == 0) begin
                b_req = 1; rand_fields(1);
            end
            #1;
            ga = 0; gb = 0;
            if (m_phase == 0) begin
                if (a_req && b_req) begin
                    if (m_last) ga = 1; else gb = 1;
                end else begin
                    ga = a_req; gb = b_req;
                end
            end
            chk("rnd.a_gnt", a_gnt, ga);
            chk("rnd.b_gnt", b_gnt, gb);
            chk("rnd.mem_we", mem_we, (m_phase == 1) && m_we);
            chk("rnd.mem_re", mem_re, (m_phase == 1) && !m_we);
            chk("rnd.mem_addr", mem_addr, m_addr);
            chk("rnd.mem_wdata", mem_wdata, m_wdata);
            chk("rnd.a_rvalid", a_rvalid, (m_phase == 2) && !m_own);
            chk("rnd.b_rvalid", b_rvalid, (m_phase == 2) && m_own);
            chk("rnd.a_rdata", a_rdata, m_rd[0]);
            chk("rnd.b_rdata", b_rdata, m_rd[1]);
            case (m_phase)
                0: if (ga || gb) begin
                    m_own   = gb;
                    m_we    = gb ? b_we    : a_we;
                    m_addr  = gb ? b_addr  : a_addr;
                    m_wdata = gb ? b_wdata : a_wdata;
                    m_last  = gb;
                    m_phase = 1;
                end
                1: begin
                    if (m_we) m_mem[m_addr[1:0]] = m_wdata;
                    else      m_rd[m_own] = m_mem[m_addr[1:0]];
                    m_phase = 2;
                end
                default: m_phase = 0;
            endcase
        end
        chk("rnd.overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
